engine_alu_ops_result_buffer: RTL

- Sits directly downstream of the ALU-ops kernel and consumes its result/result_flag output.
- The kernel pulses result_flag with no backpressure. This block captures each flagged EnginePacketData into a FIFO and re-emits it on a valid/ready stream to the engine's output port.
- It raises a programmable almost-full signal so the upstream data_valid source can be throttled before loss.
- It counts packets against a configured expected total, tags the last one, and reports done.

---
 rtl/engine_alu_ops_result_buffer_pkg.sv | 20 ++
 rtl/engine_alu_ops_result_fifo.sv | 66 ++++++
 rtl/engine_alu_ops_result_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/engine_alu_ops_result_buffer_pkg.sv
// Shared engine types used by the ALU-ops result buffer and its FIFO.
package engine_alu_ops_result_buffer_pkg;

   // Kernel result packet: four 16-bit fields, field[0] in the low bits.
   typedef struct packed {
      logic [3:0][15:0] field;
   } EnginePacketData;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } engine_alu_ops_result_buffer_state_e;

   // Bit positions within the 2-bit sticky error vector; sized to index it directly.
   localparam logic ALU_RESULT_BUFFER_ERR_OVERFLOW = 1'b0;
   localparam logic ALU_RESULT_BUFFER_ERR_EXCESS   = 1'b1;

endpackage

// File: rtl/engine_alu_ops_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding kernel result packets.
// The head entry is presented straight from the storage flops, so a push
// into an empty FIFO is visible on head_data the cycle after the write.
module engine_alu_ops_result_fifo
   import engine_alu_ops_result_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                      ap_clk,
   input  logic                      areset_n,
   input  logic                      clear,
   input  logic                      push,
   input  EnginePacketData           push_data,
   input  logic                      pop,
   output EnginePacketData           head_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);

   EnginePacketData mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // Storage write; contents need no reset because empty gates the head.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally; occupancy tracks fill level for full/empty.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            occupancy <= occupancy + (AW+1)'(1);
         end else if (!push && pop) begin
            occupancy <= occupancy - (AW+1)'(1);
         end
      end
   end

   // Status flags and zero-gated head packet.
   always_comb begin
      full      = (occupancy == (AW+1)'(DEPTH));
      empty     = (occupancy == '0);
      head_data = empty ? '0 : mem[rd_ptr];
   end

endmodule

// File: rtl/engine_alu_ops_result_buffer.sv
// Result buffer behind the ALU-ops kernel: captures flagged results into a
// FIFO, re-emits them on a valid/ready stream, throttles upstream through
// prog_full, counts packets against a configured quota and reports done.
module engine_alu_ops_result_buffer
   import engine_alu_ops_result_buffer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH          = 16,
   parameter int unsigned PROG_FULL_THRESHOLD = FIFO_DEPTH - 4,
   parameter int unsigned COUNT_WIDTH         = 32
) (
   input  logic                   ap_clk,
   input  logic                   areset_n,
   input  logic                   clear,
   input  logic                   config_valid,
   input  logic [COUNT_WIDTH-1:0] expected_count,
   input  logic                   in_valid,
   input  EnginePacketData        in_data,
   output logic                   prog_full,
   output logic                   out_valid,
   input  logic                   out_ready,
   output EnginePacketData        out_data,
   output logic                   out_last,
   output logic                   done,
   output logic [1:0]             error,
   output logic [COUNT_WIDTH-1:0] out_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   engine_alu_ops_result_buffer_state_e state_q;
   engine_alu_ops_result_buffer_state_e state_d;

   logic [COUNT_WIDTH-1:0] exp_q;
   logic [COUNT_WIDTH-1:0] in_count_q;
   logic [COUNT_WIDTH-1:0] in_count_d;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic [AW:0]            fifo_occ;
   logic [AW:0]            occ_next;
   EnginePacketData        head_data;

   logic                   push_req;
   logic                   push_en;
   logic                   pop_en;
   logic                   drop;
   logic                   excess;
   logic                   quota_hit;

   // Handshake qualification; a full FIFO still accepts when the head leaves this cycle.
   always_comb begin
      push_req   = in_valid && (state_q == RUN);
      pop_en     = !fifo_empty && out_ready;
      push_en    = push_req && (!fifo_full || pop_en);
      drop       = push_req && fifo_full && !pop_en;
      excess     = in_valid && ((state_q == DRAIN) || (state_q == DONE));
      in_count_d = (push_en && (in_count_q != '1)) ? in_count_q + COUNT_WIDTH'(1) : in_count_q;
      quota_hit  = (exp_q != '0) && (in_count_d == exp_q);
      occ_next   = fifo_occ + (AW+1)'(push_en) - (AW+1)'(pop_en);
   end

   engine_alu_ops_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .ap_clk    (ap_clk),
      .areset_n  (areset_n),
      .clear     (clear),
      .push      (push_en),
      .push_data (in_data),
      .pop       (pop_en),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_occ)
   );

   // FSM state register; clear returns to IDLE ahead of any transition.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
      end else if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; RUN leaves on the push that completes the quota so the
   // following packet is already treated as excess.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (config_valid) state_d = RUN;
         RUN:     if (quota_hit)    state_d = DRAIN;
         DRAIN:   if (fifo_empty)   state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // FSM and stream outputs.
   always_comb begin
      out_valid = !fifo_empty;
      out_data  = head_data;
      done      = (state_q == DONE);
      out_last  = !fifo_empty && (exp_q != '0) && (out_count == exp_q - COUNT_WIDTH'(1));
   end

   // Quota latch, saturating counters, sticky errors and registered prog_full.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         exp_q      <= '0;
         in_count_q <= '0;
         out_count  <= '0;
         error      <= '0;
         prog_full  <= 1'b0;
      end else if (clear) begin
         exp_q      <= '0;
         in_count_q <= '0;
         out_count  <= '0;
         error      <= '0;
         prog_full  <= 1'b0;
      end else begin
         if ((state_q == IDLE) && config_valid) begin
            exp_q <= expected_count;
         end
         in_count_q <= in_count_d;
         if (pop_en && (out_count != '1)) begin
            out_count <= out_count + COUNT_WIDTH'(1);
         end
         if (drop) begin
            error[ALU_RESULT_BUFFER_ERR_OVERFLOW] <= 1'b1;
         end
         if (excess) begin
            error[ALU_RESULT_BUFFER_ERR_EXCESS] <= 1'b1;
         end
         prog_full <= (occ_next >= (AW+1)'(PROG_FULL_THRESHOLD));
      end
   end

endmodule
